// File: rtl/dot_matrix_scanner_pkg.sv
// Shared definitions for the LED dot-matrix display blocks.
//   ROWS / COLS : matrix geometry (16 x 16)
//   ROW_BITS    : width of the binary row index
//   scan_state_e: row-scan controller states
package dot_matrix_scanner_pkg;

    localparam int ROWS     = 16;
    localparam int COLS     = 16;
    localparam int ROW_BITS = $clog2(ROWS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/dot_matrix_scanner_scan_timer.sv
// Row-slot counter for the dot-matrix scanner.
// A slot is DIV cycles long: counts 0..BLANK-1 (dark), then BLANK..DIV-1 (lit).
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   clr        : synchronous clear, wins over run
//   run        : advance the counter this cycle
//   blank_done : last dark cycle of the slot
//   slot_done  : last cycle of the slot
module scan_timer #(
    parameter int DIV   = 1000,
    parameter int BLANK = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic blank_done,
    output logic slot_done
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            // Wrapping at DIV-1 lands on 0, the first dark cycle of the next slot.
            cnt <= (cnt == DIV_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign blank_done = run && (cnt == BLANK_LAST);
    assign slot_done  = run && (cnt == DIV_LAST);

endmodule

// File: rtl/dot_matrix_scanner.sv
// Row-scan driver for the 16x16 LED dot matrix.
// Steps row_bin into the pattern ROM, latches the returned column word once per
// slot, and drives one-hot rows plus registered columns with a dark gap first.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   en         : scan enable, low forces the display dark
//   col_in     : column word from pattern ROM for row_bin
//   row_bin    : row index to pattern ROM
//   row        : one-hot active-high row enables
//   col        : registered active-high column drive
//   frame_tick : one-cycle pulse when row_bin wraps 15 -> 0
//
// state   | meaning
// S_IDLE  | scan stopped, display dark, row_bin held
// S_BLANK | dark gap before a row, ROM settling on row_bin
// S_SHOW  | row lit with the column word latched at the end of S_BLANK
module dot_matrix_scanner
    import dot_matrix_scanner_pkg::*;
#(
    parameter int DIV   = 1000,
    parameter int BLANK = 50
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [COLS-1:0]     col_in,
    output logic [ROW_BITS-1:0] row_bin,
    output logic [ROWS-1:0]     row,
    output logic [COLS-1:0]     col,
    output logic                frame_tick
);

    localparam logic [ROWS-1:0]     ROW_ONE  = ROWS'(1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS - 1);

    scan_state_e         state, state_nxt;
    logic [ROW_BITS-1:0] row_bin_nxt;
    logic [ROWS-1:0]     row_nxt;
    logic [COLS-1:0]     col_nxt;
    logic                tick_nxt;
    logic                timer_clr;
    logic                timer_run;
    logic                blank_done;
    logic                slot_done;

    assign timer_clr = !en;
    assign timer_run = (state != S_IDLE);

    scan_timer #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_scan_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (timer_clr),
        .run        (timer_run),
        .blank_done (blank_done),
        .slot_done  (slot_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            row_bin    <= '0;
            row        <= '0;
            col        <= '0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            row_bin    <= row_bin_nxt;
            row        <= row_nxt;
            col        <= col_nxt;
            frame_tick <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        row_bin_nxt = row_bin;
        row_nxt     = row;
        col_nxt     = col;
        tick_nxt    = 1'b0;
        if (!en) begin
            // row_bin is deliberately held so re-enable resumes on the same row.
            state_nxt = S_IDLE;
            row_nxt   = '0;
            col_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_BLANK;
                    row_nxt   = '0;
                    col_nxt   = '0;
                end
                S_BLANK: begin
                    row_nxt = '0;
                    col_nxt = '0;
                    if (blank_done) begin
                        state_nxt = S_SHOW;
                        row_nxt   = ROW_ONE << row_bin;
                        col_nxt   = col_in;
                    end
                end
                S_SHOW: begin
                    if (slot_done) begin
                        state_nxt   = S_BLANK;
                        row_nxt     = '0;
                        col_nxt     = '0;
                        row_bin_nxt = row_bin + ROW_BITS'(1);
                        tick_nxt    = (row_bin == ROW_LAST);
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    row_nxt   = '0;
                    col_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_matrix_scanner.sv
module tb_dot_matrix_scanner;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 16 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] col_in;
    logic [3:0]  row_bin;
    logic [15:0] row;
    logic [15:0] col;
    logic        frame_tick;

    // Pattern ROM stand-in, with an override to disturb col_in mid-slot.
    logic [15:0] rom [16];
    logic        ovr = 1'b0;
    logic [15:0] ovr_val = 16'h0000;

    always_comb col_in = ovr ? ovr_val : rom[row_bin];

    always #5 clk = ~clk;

    dot_matrix_scanner #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .col_in     (col_in),
        .row_bin    (row_bin),
        .row        (row),
        .col        (col),
        .frame_tick (frame_tick)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: elapsed cycles since the scan started (m_n) give the
    // slot position by plain modulo arithmetic.
    bit          m_act;
    int          m_n;
    int          m_rb;
    logic [15:0] m_row;
    logic [15:0] m_col;
    logic        m_tick;

    function automatic void model_reset();
        m_act  = 1'b0;
        m_n    = 0;
        m_rb   = 0;
        m_row  = '0;
        m_col  = '0;
        m_tick = 1'b0;
    endfunction

    function automatic int m_pos();
        return m_n % DIV;
    endfunction

    task automatic step();
        int pos;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else if (!en) begin
            m_act  = 1'b0;
            m_row  = '0;
            m_col  = '0;
            m_tick = 1'b0;
        end else if (!m_act) begin
            m_act  = 1'b1;
            m_n    = 0;
            m_row  = '0;
            m_col  = '0;
            m_tick = 1'b0;
        end else begin
            m_n++;
            pos    = m_n % DIV;
            m_tick = 1'b0;
            if (pos == 0) begin
                m_rb   = (m_rb + 1) % 16;
                m_tick = (m_rb == 0);
                m_row  = '0;
                m_col  = '0;
            end
            if (pos == BLANK) begin
                m_row = 16'h0001 << m_rb;
                m_col = rom[m_rb];
            end
        end
        #1;
    endtask

    task automatic do_reset();
        en    = 1'b0;
        ovr   = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        step();
        n_cmp++;
        if ({row_bin, row, col, frame_tick} !== 37'd0) begin
            n_bad++;
            $display("FAIL reset_values got rb=%0d row=%h col=%h tick=%b need all zero",
                     row_bin, row, col, frame_tick);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if ({row_bin, row, col, frame_tick} !== {4'(m_rb), m_row, m_col, m_tick}) begin
                n_bad++;
                $display("FAIL idle_model cyc=%0d got rb=%0d row=%h col=%h tick=%b need rb=%0d row=%h col=%h tick=%b",
                         cyc, row_bin, row, col, frame_tick, m_rb, m_row, m_col, m_tick);
            end
        end
    endtask

    task automatic test_single_slot();
        do_reset();
        rom[0] = 16'($urandom);
        rom[1] = 16'h0FF0;
        for (int r = 2; r <= 12; r++) rom[r] = 16'h0810;
        en = 1'b1;
        for (int i = 1; i <= 1 + 3 * DIV; i++) begin
            step();
            n_cmp++;
            if ({row_bin, row, col, frame_tick} !== {4'(m_rb), m_row, m_col, m_tick}) begin
                n_bad++;
                $display("FAIL slot_model cyc=%0d got rb=%0d row=%h col=%h tick=%b need rb=%0d row=%h col=%h tick=%b",
                         cyc, row_bin, row, col, frame_tick, m_rb, m_row, m_col, m_tick);
            end
            if (i == 2) begin
                n_cmp++;
                if (row !== 16'h0000) begin
                    n_bad++;
                    $display("FAIL slot0_dark got row=%h need 0000", row);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (row !== 16'h0001) begin
                    n_bad++;
                    $display("FAIL slot0_lit got row=%h need 0001", row);
                end
            end
            if (i == 1 + DIV + 1) begin
                n_cmp++;
                if ({row_bin, row} !== {4'd1, 16'h0000}) begin
                    n_bad++;
                    $display("FAIL slot1_dark got rb=%0d row=%h need rb=1 row=0000", row_bin, row);
                end
            end
            if (i == 1 + DIV + BLANK) begin
                n_cmp++;
                if ({row, col} !== {16'h0002, 16'h0FF0}) begin
                    n_bad++;
                    $display("FAIL slot1_lit got row=%h col=%h need row=0002 col=0ff0", row, col);
                end
            end
            if (i == 1 + 2 * DIV + BLANK) begin
                n_cmp++;
                if ({row, col} !== {16'h0004, 16'h0810}) begin
                    n_bad++;
                    $display("FAIL slot2_lit got row=%h col=%h need row=0004 col=0810", row, col);
                end
            end
        end
    endtask

    task automatic test_frame_wrap();
        int ticks;
        int first_t;
        int second_t;
        do_reset();
        for (int r = 0; r < 16; r++) rom[r] = 16'($urandom);
        ticks    = 0;
        first_t  = -1;
        second_t = -1;
        en = 1'b1;
        for (int i = 1; i <= 2 * FRAME + 10; i++) begin
            step();
            n_cmp++;
            if ({row_bin, row, col, frame_tick} !== {4'(m_rb), m_row, m_col, m_tick}) begin
                n_bad++;
                $display("FAIL wrap_model cyc=%0d got rb=%0d row=%h col=%h tick=%b need rb=%0d row=%h col=%h tick=%b",
                         cyc, row_bin, row, col, frame_tick, m_rb, m_row, m_col, m_tick);
            end
            if (frame_tick === 1'b1) begin
                ticks++;
                if (ticks == 1) first_t = i;
                if (ticks == 2) second_t = i;
            end
        end
        n_cmp++;
        if (ticks != 2) begin
            n_bad++;
            $display("FAIL wrap_tick_count got %0d need 2", ticks);
        end
        n_cmp++;
        if (first_t != 1 + FRAME) begin
            n_bad++;
            $display("FAIL wrap_first_tick got step %0d need step %0d", first_t, 1 + FRAME);
        end
        n_cmp++;
        if (second_t - first_t != FRAME) begin
            n_bad++;
            $display("FAIL wrap_tick_period got %0d need %0d", second_t - first_t, FRAME);
        end
    endtask

    task automatic test_mid_slot_disable();
        bit found;
        do_reset();
        en    = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            step();
            n_cmp++;
            if ({row_bin, row, col, frame_tick} !== {4'(m_rb), m_row, m_col, m_tick}) begin
                n_bad++;
                $display("FAIL dis_model cyc=%0d got rb=%0d row=%h col=%h tick=%b need rb=%0d row=%h col=%h tick=%b",
                         cyc, row_bin, row, col, frame_tick, m_rb, m_row, m_col, m_tick);
            end
            if (m_rb == 5 && m_pos() == BLANK + 1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL dis_reach_row5 got timeout need show of row 5");
        end
        en = 1'b0;
        step();
        n_cmp++;
        if ({row, col, row_bin} !== {16'h0000, 16'h0000, 4'd5}) begin
            n_bad++;
            $display("FAIL dis_dark got row=%h col=%h rb=%0d need row=0000 col=0000 rb=5", row, col, row_bin);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({row_bin, row, col, frame_tick} !== {4'(m_rb), m_row, m_col, m_tick}) begin
                n_bad++;
                $display("FAIL dis_idle cyc=%0d got rb=%0d row=%h col=%h tick=%b need rb=%0d row=%h col=%h tick=%b",
                         cyc, row_bin, row, col, frame_tick, m_rb, m_row, m_col, m_tick);
            end
        end
        en = 1'b1;
        for (int i = 1; i <= 1 + BLANK; i++) begin
            step();
            n_cmp++;
            if (row !== ((i == 1 + BLANK) ? 16'h0020 : 16'h0000)) begin
                n_bad++;
                $display("FAIL reen_row step=%0d got row=%h need %h", i, row,
                         (i == 1 + BLANK) ? 16'h0020 : 16'h0000);
            end
        end
    endtask

    task automatic test_col_sampling();
        bit found;
        do_reset();
        for (int r = 0; r < 16; r++) rom[r] = 16'h0810;
        en    = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            step();
            if (m_rb == 3 && m_pos() == BLANK) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL col_reach_row3 got timeout need show of row 3");
        end
        step();
        step();
        ovr_val = 16'hFFFF;
        ovr     = 1'b1;
        for (int k = 0; k < DIV - 1 - (BLANK + 2); k++) begin
            step();
            n_cmp++;
            if (col !== 16'h0810) begin
                n_bad++;
                $display("FAIL col_hold cyc=%0d got col=%h need 0810", cyc, col);
            end
        end
        ovr = 1'b0;
        for (int i = 0; i < DIV; i++) begin
            step();
            n_cmp++;
            if ({row_bin, row, col, frame_tick} !== {4'(m_rb), m_row, m_col, m_tick}) begin
                n_bad++;
                $display("FAIL col_model cyc=%0d got rb=%0d row=%h col=%h tick=%b need rb=%0d row=%h col=%h tick=%b",
                         cyc, row_bin, row, col, frame_tick, m_rb, m_row, m_col, m_tick);
            end
        end
    endtask

    task automatic test_async_reset();
        bit found;
        do_reset();
        for (int r = 0; r < 16; r++) rom[r] = 16'($urandom) | 16'h0001;
        en    = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            step();
            if (m_rb == 7 && m_pos() == BLANK + 1) found = 1'b1;
        end
        n_cmp++;
        if (!found || row !== 16'h0080) begin
            n_bad++;
            $display("FAIL arst_setup got row=%h need 0080", row);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({row, col, row_bin, frame_tick} !== 37'd0) begin
            n_bad++;
            $display("FAIL arst_immediate got row=%h col=%h rb=%0d tick=%b need all zero",
                     row, col, row_bin, frame_tick);
        end
        model_reset();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < DIV + 2; i++) begin
            step();
            n_cmp++;
            if ({row_bin, row, col, frame_tick} !== {4'(m_rb), m_row, m_col, m_tick}) begin
                n_bad++;
                $display("FAIL arst_model cyc=%0d got rb=%0d row=%h col=%h tick=%b need rb=%0d row=%h col=%h tick=%b",
                         cyc, row_bin, row, col, frame_tick, m_rb, m_row, m_col, m_tick);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int r = 0; r < 16; r++) rom[r] = 16'($urandom);
        for (int i = 0; i < 3 * FRAME; i++) begin
            en = ($urandom_range(0, 99) < 96);
            step();
            n_cmp++;
            if ({row_bin, row, col, frame_tick} !== {4'(m_rb), m_row, m_col, m_tick}) begin
                n_bad++;
                $display("FAIL rand_model cyc=%0d got rb=%0d row=%h col=%h tick=%b need rb=%0d row=%h col=%h tick=%b",
                         cyc, row_bin, row, col, frame_tick, m_rb, m_row, m_col, m_tick);
            end
            n_cmp++;
            if ($countones(row) > 1 || (row == 16'h0000 && col != 16'h0000)) begin
                n_bad++;
                $display("FAIL rand_onehot cyc=%0d got row=%h col=%h need one-hot row, dark col when row off",
                         cyc, row, col);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) rom[r] = 16'h0000;
        model_reset();
        test_reset();
        test_single_slot();
        test_frame_wrap();
        test_mid_slot_disable();
        test_col_sampling();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got time limit need bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dot_matrix_scanner.md
Name: dot_matrix_scanner

Overview:
Row-scan driver for the 16x16 LED dot-matrix display. It steps a 4-bit row index, row_bin, that feeds the downstream combinational pattern ROM, and registers the 16-bit column word the ROM returns. It drives one-hot row enables and the registered columns to the matrix pins. A blanking gap before each row prevents ghosting, and the block pulses frame_tick once per full 16-row sweep.

Parameters:
DIV, 1000, clock cycles per row slot (blank plus lit); legal when DIV > BLANK.
BLANK, 50, cycles per slot with all rows and columns off; legal when BLANK >= 1.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  scan enable; low forces display dark
col_in  input  16  column word from pattern ROM for current row_bin (combinational, settles within one cycle)
row_bin  output  4  row index to pattern ROM, registered
row  output  16  one-hot row enable, active-high, bit k = row k
col  output  16  registered column drive, active-high
frame_tick  output  1  one-cycle pulse when row_bin wraps 15 -> 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, row_bin=0, row=0, col=0, frame_tick=0, slot counter cnt=0.
- States:
  - IDLE: row=0, col=0, cnt=0. en=1 -> BLANK on the next edge; row_bin is unchanged.
  - BLANK: row=0, col=0. cnt counts 0..BLANK-1. When cnt==BLANK-1, on the next edge: col<=col_in, row<=(1<<row_bin), go to SHOW, cnt<=BLANK.
  - SHOW: row and col are held. cnt counts BLANK..DIV-1. When cnt==DIV-1, on the next edge:
    - row<=0, col<=0, cnt<=0, go to BLANK.
    - row_bin<=row_bin+1 (mod 16).
    - frame_tick<=1 only if row_bin was 15.
- Timing:
  - Each row slot is exactly DIV cycles: BLANK dark, then DIV-BLANK lit.
  - A full frame is 16*DIV cycles.
- row_bin changes only at entry to BLANK. The ROM therefore has BLANK >= 1 cycles to settle before col_in is sampled.
- frame_tick:
  - High for exactly one cycle, aligned with the first BLANK cycle of row 0.
  - It is never asserted after leaving IDLE unless a 15 -> 0 wrap has occurred.
- en deasserted in any state:
  - Next edge: IDLE, row=0, col=0, cnt=0, frame_tick=0.
  - row_bin is held, so re-enabling resumes at the same row with a full BLANK.
- en toggled within one cycle: no glitch on row or col. Outputs change only on clk edges.
- col_in changing during SHOW has no effect. It is sampled once per slot.
- At most one row bit is high at any time. Row and col are never both driven during BLANK.
- cnt width is $clog2(DIV). No other arithmetic; row_bin wrap relies on 4-bit overflow.

Decomposition:
- Shared package: constant ROWS=16, column width COLS=16, and the state enum {IDLE, BLANK, SHOW}, for reuse by later display blocks.
- One natural sub-module, scan_timer:
  - Contains the DIV/BLANK slot counter.
  - Outputs blank_done and slot_done strobes, with a synchronous clear driven by en.
  - The FSM and output registers stay in dot_matrix_scanner.

Test Plan:
- Reset and idle: rst_n=0 then 1 with en=0 for 20 cycles -> row=0, col=0, row_bin=0, frame_tick=0 throughout.
- Single slot (DIV=8, BLANK=2): ROM model returns 16'h0FF0 for row 1 and 16'h0810 for rows 2-12; en=1.
  - Slot 0: 2 dark cycles, then row=16'h0001 for 6 cycles.
  - Next slot: row_bin=1, 2 dark cycles, then row=16'h0002, col=16'h0FF0.
  - Next slot: row=16'h0004, col=16'h0810.
- Frame wrap: run 16*8=128 cycles from enable.
  - frame_tick is high exactly once, in the cycle row_bin returns to 0.
  - The second frame's tick arrives 128 cycles later.
- Mid-slot disable: drop en during SHOW of row 5.
  - Next edge: row=0, col=0, row_bin=5.
  - Re-enable: 2 dark cycles, then row=16'h0020.
- col_in sampling: change col_in from 16'h0810 to 16'hFFFF in the third cycle of SHOW -> col remains 16'h0810 until the slot ends.
- Async reset mid-SHOW: assert rst_n=0 between edges -> row, col and row_bin go to 0 immediately, without waiting for clk.
